// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU register-bank blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tiny_cpu_pkg;

   // Default register width of the CPU load-enable registers
   localparam int WIDTH_DEFAULT = 8;

   // Serializer FSM encoding; 2'b11 is unused and recovers to IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // clog2 that never returns less than 1, for index/counter widths
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out shift register, LSB presented first.
// Latency: load or shift takes effect at the next rising edge; sout is a register bit.
// Backpressure: holds contents whenever shift is low.
module piso_shift #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         sout
);

   logic [W-1:0] sreg;

   // Clear wins over load, load wins over shift; shifting brings in zeros
   always_ff @(posedge clk) begin
      if (!clr) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= din;
      end else if (shift) begin
         sreg <= sreg >> 1;
      end
   end

   assign sout = sreg[0];

endmodule

// File: rtl/reg_readout_serializer.sv
// Snapshots a register bank and streams it out bit-serially, reg 0 first, LSB first.
// Latency: first bit valid the cycle after Start; Done one cycle after the last transfer.
// Backpressure: Ready=0 holds SerOut/SerLast/RegIdx stable with SerValid kept high.
module reg_readout_serializer
   import tiny_cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int NREGS = 4,
   localparam int NBITS = NREGS * WIDTH,
   localparam int CW    = clog2_min1(NBITS),
   localparam int RW    = clog2_min1(NREGS)
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             Start,
   input  logic [NBITS-1:0] Qin,
   input  logic             Ready,
   output logic             SerOut,
   output logic             SerValid,
   output logic             SerLast,
   output logic [RW-1:0]    RegIdx,
   output logic             Busy,
   output logic             Done
);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          shadow_bit;
   logic          load;
   logic          xfer;
   logic          at_last;

   // Capture only from IDLE; a transfer is only possible while shifting
   assign load    = (state == ST_IDLE) && Start;
   assign xfer    = (state == ST_SHIFT) && Ready;
   assign at_last = (cnt == CW'(NBITS - 1));

   // Shadow copy of the bank; isolates the frame from later Qin changes
   piso_shift #(
      .W(NBITS)
   ) u_shadow (
      .clk   (CLK),
      .clr   (CLR),
      .load  (load),
      .shift (xfer),
      .din   (Qin),
      .sout  (shadow_bit)
   );

   // State register; reset takes priority over any Start in the same cycle
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bit counter: cleared on frame entry, advanced once per accepted bit
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (xfer) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Next-state and output decode; outputs depend only on state and registers
   always_comb begin
      state_nxt = state;
      SerOut    = 1'b0;
      SerValid  = 1'b0;
      SerLast   = 1'b0;
      RegIdx    = '0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start) begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            SerValid = 1'b1;
            Busy     = 1'b1;
            SerOut   = shadow_bit;
            SerLast  = at_last;
            RegIdx   = RW'(int'(cnt) / WIDTH);
            if (Ready && at_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            Done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_readout_serializer.sv
// Directed bench for reg_readout_serializer with a frame-level reference model.
// Latency: model predicts per-cycle outputs from Start/Ready/CLR history.
// Backpressure: Ready patterns are driven by the bench to exercise stalls.
module tb_reg_readout_serializer;

   localparam int WIDTH = 8;
   localparam int NREGS = 4;
   localparam int NB    = WIDTH * NREGS;
   localparam logic [31:0] PATTERN = 32'h80013CA5;

   logic          CLK = 1'b0;
   logic          CLR;
   logic          Start;
   logic [NB-1:0] Qin;
   logic          Ready;
   logic          SerOut;
   logic          SerValid;
   logic          SerLast;
   logic [1:0]    RegIdx;
   logic          Busy;
   logic          Done;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   reg_readout_serializer #(
      .WIDTH(WIDTH),
      .NREGS(NREGS)
   ) dut (
      .CLK      (CLK),
      .CLR      (CLR),
      .Start    (Start),
      .Qin      (Qin),
      .Ready    (Ready),
      .SerOut   (SerOut),
      .SerValid (SerValid),
      .SerLast  (SerLast),
      .RegIdx   (RegIdx),
      .Busy     (Busy),
      .Done     (Done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired at %0t", nm, $time);
   endtask

   // Frame-level model: a captured frame word, a position in it, and a done flag
   bit          m_act  = 1'b0;
   bit          m_done = 1'b0;
   int          m_pos  = 0;
   logic [NB-1:0] m_frame = '0;

   always @(posedge CLK) begin
      if (!CLR) begin
         m_act   = 1'b0;
         m_done  = 1'b0;
         m_pos   = 0;
         m_frame = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_act) begin
         if (Ready) begin
            if (m_pos == NB - 1) begin
               m_act  = 1'b0;
               m_done = 1'b1;
            end else begin
               m_pos++;
            end
         end
      end else if (Start) begin
         m_frame = Qin;
         m_pos   = 0;
         m_act   = 1'b1;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge CLK) begin
      if (chk_en) begin
         check("SerValid", SerValid, m_act);
         check("Busy",     Busy,     m_act);
         check("Done",     Done,     m_done);
         check("SerOut",   SerOut,   m_act ? m_frame[m_pos] : 1'b0);
         check("SerLast",  SerLast,  m_act && (m_pos == NB - 1));
         check("RegIdx",   RegIdx,   m_act ? (m_pos / WIDTH) : 0);
      end
   end

   // Runs one frame from the negedge after Start was raised; gathers what the link carried
   task automatic collect(input bit bp, input int rst_at, input int restart_at, input bit chg,
                          output logic [31:0] w, output int vcyc, output int ndone,
                          output int last_idx, output int nlast, output int gap);
      int nb = 0;
      int t_last = -1;
      int t_done = -1;
      bit fin = 1'b0;
      bit aborted = 1'b0;
      w = '0; vcyc = 0; ndone = 0; last_idx = -1; nlast = 0; gap = -1;
      for (int t = 0; t < 300 && !fin; t++) begin
         @(negedge CLK);
         Start = 1'b0;
         CLR   = 1'b1;
         if (Done) begin
            ndone++;
            if (t_done < 0) begin
               t_done = t;
               if (restart_at >= 0) Start = 1'b1;
            end
         end else if (ndone > 0 || (aborted && !SerValid)) begin
            fin = 1'b1;
         end
         if (SerValid) begin
            if (chg && vcyc == 0) Qin = 32'hFFFFFFFF;
            Ready = bp ? ((vcyc % 4 == 0) || (vcyc % 4 == 3)) : 1'b1;
            if (vcyc == restart_at) Start = 1'b1;
            if (vcyc == rst_at) begin
               CLR = 1'b0;
               aborted = 1'b1;
            end
            if (Ready && CLR) begin
               if (nb < 32) w[nb] = SerOut;
               if (SerLast) begin
                  nlast++;
                  last_idx = nb;
                  t_last = t;
               end
               nb++;
            end
            vcyc++;
         end
      end
      if (!fin) fail_now("collect_timeout");
      if (t_done >= 0 && t_last >= 0) gap = t_done - t_last;
      Ready = 1'b1;
   endtask

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      int vcyc, ndone, last_idx, nlast, gap;

      CLR = 1'b0; Start = 1'b0; Ready = 1'b1; Qin = PATTERN;
      repeat (2) @(negedge CLK);
      check("rst_SerValid", SerValid, 0);
      check("rst_SerOut",   SerOut,   0);
      check("rst_SerLast",  SerLast,  0);
      check("rst_RegIdx",   RegIdx,   0);
      check("rst_Busy",     Busy,     0);
      check("rst_Done",     Done,     0);
      chk_en = 1'b1;
      CLR = 1'b1;
      @(negedge CLK);

      // 1: full-rate frame
      Start = 1'b1;
      collect(1'b0, -1, -1, 1'b0, w, vcyc, ndone, last_idx, nlast, gap);
      check("s1_word",     w,        PATTERN);
      check("s1_cycles",   vcyc,     32);
      check("s1_ndone",    ndone,    1);
      check("s1_nlast",    nlast,    1);
      check("s1_last_idx", last_idx, 31);
      check("s1_done_gap", gap,      1);

      // 2: Ready pattern 1,0,0,1
      @(negedge CLK);
      Start = 1'b1;
      collect(1'b1, -1, -1, 1'b0, w, vcyc, ndone, last_idx, nlast, gap);
      check("s2_word",     w,        PATTERN);
      check("s2_cycles",   vcyc,     64);
      check("s2_ndone",    ndone,    1);
      check("s2_last_idx", last_idx, 31);

      // 3: Qin overwritten right after capture
      @(negedge CLK);
      Start = 1'b1;
      collect(1'b0, -1, -1, 1'b1, w, vcyc, ndone, last_idx, nlast, gap);
      check("s3_word",  w,     PATTERN);
      check("s3_ndone", ndone, 1);
      Qin = PATTERN;

      // 4: Start re-pulsed in SHIFT and in DONE
      @(negedge CLK);
      Start = 1'b1;
      collect(1'b0, -1, 5, 1'b0, w, vcyc, ndone, last_idx, nlast, gap);
      check("s4_word",   w,     PATTERN);
      check("s4_cycles", vcyc,  32);
      check("s4_ndone",  ndone, 1);
      repeat (3) @(negedge CLK);
      check("s4_idle_after", SerValid, 0);

      // 5: reset during bit 12, then a fresh frame
      @(negedge CLK);
      Start = 1'b1;
      collect(1'b0, 12, -1, 1'b0, w, vcyc, ndone, last_idx, nlast, gap);
      check("s5_ndone",    ndone,    0);
      check("s5_SerValid", SerValid, 0);
      check("s5_Busy",     Busy,     0);
      check("s5_partial",  w,        PATTERN & 32'h00000FFF);
      @(negedge CLK);
      Start = 1'b1;
      collect(1'b0, -1, -1, 1'b0, w, vcyc, ndone, last_idx, nlast, gap);
      check("s5_fresh_word",  w,     PATTERN);
      check("s5_fresh_ndone", ndone, 1);

      // 6: Start coincident with reset
      @(negedge CLK);
      Start = 1'b1;
      CLR   = 1'b0;
      @(negedge CLK);
      Start = 1'b0;
      CLR   = 1'b1;
      check("s6_SerValid", SerValid, 0);
      check("s6_Busy",     Busy,     0);
      repeat (3) @(negedge CLK);
      check("s6_still_idle", SerValid, 0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_readout_serializer.md
# reg_readout_serializer

Read-side counterpart to the CPU's 8-bit load-enable registers: takes a snapshot of the parallel `Qout` values of a bank of registers and streams them out one bit per accepted transfer over a valid/ready serial link. It sits between the register bank and the debug/observation port, so register contents can be dumped without stalling the datapath. One start pulse produces one complete frame covering all registers, register 0 first and LSB first within each register.

## Interface
- `WIDTH`, 8, bits per register.
- `NREGS`, 4, registers per frame (≥1).
- `CLK`  in  1  clock; all state changes on the rising edge.
- `CLR`  in  1  reset: synchronous, active-low. `CLR=0` at a rising `CLK` resets the block.
- `Start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `Qin`  in  NREGS*WIDTH  parallel register contents; register i occupies `Qin[i*WIDTH +: WIDTH]`.
- `Ready`  in  1  downstream accepts the current bit.
- `SerOut`  out  1  current data bit.
- `SerValid`  out  1  `SerOut` is valid.
- `SerLast`  out  1  current bit is the final bit of the frame.
- `RegIdx`  out  clog2(NREGS) (min 1)  index of the register being sent.
- `Busy`  out  1  frame in progress (SHIFT state).
- `Done`  out  1  one-cycle pulse after the final bit is accepted.

## Operation
- States:
  - IDLE: outputs quiet.
  - SHIFT: sending bits.
  - DONE: one cycle, then back to IDLE.
- IDLE, `Start=1`:
  - Capture `Qin` into a shadow register.
  - Clear the bit counter to 0.
  - Go to SHIFT.
- SHIFT:
  - `SerValid=1`; `SerOut` = shadow bit 0.
  - A transfer is `SerValid && Ready` at a rising edge. On each transfer: shadow shifts right by 1 and the counter increments.
  - `RegIdx` = counter / WIDTH.
  - `SerLast=1` when counter = NREGS*WIDTH−1.
  - A transfer with `SerLast=1` goes to DONE.
- DONE: `Done=1` and `SerValid=0` for one cycle, then IDLE.
- Backpressure: while `Ready=0`, `SerOut`, `SerLast` and `RegIdx` hold stable and `SerValid` stays 1. `SerValid` never drops mid-frame.
- Changes on `Qin` after capture have no effect on the frame in progress.
- `Start` in SHIFT or DONE is ignored and not queued.
- Reset (`CLR=0`), including mid-frame:
  - Next state IDLE; frame abandoned, no `Done`.
  - Outputs after the edge: `SerOut=0`, `SerValid=0`, `SerLast=0`, `RegIdx=0`, `Busy=0`, `Done=0`.
  - Shadow register and counter cleared to 0.
- Reset and `Start` at the same edge: reset wins.
- All outputs are registered or decoded only from state/registers. There is no combinational path from `Ready` or `Start` to any output.

## Timing
- `Start` sampled at edge k → `SerValid=1` with bit 0 of register 0 after edge k.
- With `Ready` held high, one bit per cycle:
  - The last transfer occurs at edge k+NREGS*WIDTH.
  - `Done` is high for the cycle after that edge; IDLE follows at the next edge.
- Earliest new `Start` is sampled in IDLE, i.e. at edge k+NREGS*WIDTH+2.
- A `Start` sampled while in DONE is dropped.
- Counter width is clog2(NREGS*WIDTH). It never wraps within a frame: it is reset on entry to SHIFT.

## Structure
- Shared package `tiny_cpu_pkg` holds:
  - The state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10). The unused encoding 2'b11 recovers to IDLE.
  - The `WIDTH` default constant.
- Sub-module `piso_shift`: a parameterised parallel-in/serial-out register with `load` and `shift` enables, synchronous active-low clear, and LSB output. The top level holds the FSM, the counter and the output decode.

## Test plan
1. NREGS=4, `Qin=32'h80013CA5`, `Ready` held 1, `Start` pulsed:
   - 32 consecutive bits: A5 LSB-first (1,0,1,0,0,1,0,1), then 3C, 01, 80.
   - `RegIdx` steps 0→3 every 8 bits.
   - `SerLast` set only on bit 31; `Done` pulses once, exactly one cycle after the bit-31 transfer.
2. Backpressure: same frame, `Ready` toggled 1,0,0,1 repeating.
   - Bit sequence identical to scenario 1.
   - Outputs stable during `Ready=0` cycles; total frame time 64 cycles.
3. Snapshot isolation: change `Qin` to 32'hFFFFFFFF one cycle after `Start` → the stream still carries 80013CA5.
4. `Start` re-pulsed during SHIFT and during DONE → ignored; exactly one frame, one `Done`.
5. `CLR=0` for one edge during bit 12 → all outputs 0 next cycle, no `Done`. A later `Start` sends a full fresh 32-bit frame.
6. `Start` and `CLR=0` at the same edge → remains IDLE, `SerValid=0`.
